// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared constants and types for the MIPS memory stage
package mem_stage_pkg;

    localparam int MEM_READ_BIT  = 1;
    localparam int MEM_WRITE_BIT = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  write_register;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX/MEM inputs and MEM/WB outputs of the memory stage
interface mem_stage_if;

    logic [1:0]  WB_in;
    logic [1:0]  M_in;
    logic [31:0] ALUresult_in;
    logic [31:0] write_mem_data_in;
    logic [4:0]  write_register_in;
    logic        stall;
    logic [1:0]  WB_out;
    logic [31:0] read_data_out;
    logic [31:0] ALUresult_out;
    logic [4:0]  write_register_out;

    modport master (
        output WB_in, M_in, ALUresult_in, write_mem_data_in, write_register_in,
        input  stall, WB_out, read_data_out, ALUresult_out, write_register_out
    );

    modport slave (
        input  WB_in, M_in, ALUresult_in, write_mem_data_in, write_register_in,
        output stall, WB_out, read_data_out, ALUresult_out, write_register_out
    );

endinterface

// File: rtl/mem_stage_data_mem.sv
// rtl/mem_stage_data_mem.sv - word-addressed data memory, synchronous write, combinational read
module data_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    // Contents deliberately survive reset; only the pipeline state is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: fixed-latency load/store with upstream stall and MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CW-1:0] LAT_C = CW'(LATENCY);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    mem_wb_t       mem_wb_q, mem_wb_d;

    logic          mem_read, mem_write, access, is_load;
    logic          we, complete, stall;
    logic [AW-1:0] idx;
    logic [31:0]   rdata;
    mem_wb_t       pass_fields, done_fields;

    assign mem_read  = bus.M_in[MEM_READ_BIT];
    assign mem_write = bus.M_in[MEM_WRITE_BIT];
    assign access    = mem_read | mem_write;
    // Both control bits set behaves as a store, so only a pure read returns data.
    assign is_load   = mem_read & ~mem_write;
    assign idx       = bus.ALUresult_in[AW+1:2];

    data_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_mem (
        .clk   (clk),
        .we    (we),
        .addr  (idx),
        .wdata (bus.write_mem_data_in),
        .rdata (rdata)
    );

    assign pass_fields = '{wb: bus.WB_in, read_data: 32'd0,
                           alu_result: bus.ALUresult_in,
                           write_register: bus.write_register_in};
    assign done_fields = '{wb: bus.WB_in, read_data: (is_load ? rdata : 32'd0),
                           alu_result: bus.ALUresult_in,
                           write_register: bus.write_register_in};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_wb_d = pass_fields;
        stall    = 1'b0;
        complete = 1'b0;
        we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (LATENCY == 0) begin
                        complete = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        state_d  = WAIT;
                        cnt_d    = CW'(1);
                        mem_wb_d = MEM_WB_BUBBLE;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != LAT_C) begin
                    stall    = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    mem_wb_d = MEM_WB_BUBBLE;
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (complete) begin
            we       = mem_write;
            mem_wb_d = done_fields;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mem_wb_q <= MEM_WB_BUBBLE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign bus.stall              = stall;
    assign bus.WB_out             = mem_wb_q.wb;
    assign bus.read_data_out      = mem_wb_q.read_data;
    assign bus.ALUresult_out      = mem_wb_q.alu_result;
    assign bus.write_register_out = mem_wb_q.write_register;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage (LATENCY 2 and LATENCY 0 builds)
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_stage_if b2 ();
    mem_stage_if b0 ();

    mem_stage #(.LATENCY(2), .DEPTH(256)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
    mem_stage #(.LATENCY(0), .DEPTH(256)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));

    int tests = 0;
    int fails = 0;
    logic [31:0] ref2 [256];
    logic [31:0] ref0 [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) % 256);
    endfunction

    task automatic chk_zero2(input string tag);
        chk({tag, "_wb"},   {30'd0, b2.WB_out}, 32'd0);
        chk({tag, "_rd"},   b2.read_data_out, 32'd0);
        chk({tag, "_alu"},  b2.ALUresult_out, 32'd0);
        chk({tag, "_wreg"}, {27'd0, b2.write_register_out}, 32'd0);
    endtask

    // Called just after a falling edge; returns just after the completing rising edge.
    task automatic op2(input logic [1:0] m, input logic [1:0] wb, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] wr);
        logic [31:0] exp_rd;
        int i;
        b2.M_in = m; b2.WB_in = wb; b2.ALUresult_in = addr;
        b2.write_mem_data_in = data; b2.write_register_in = wr;
        i = widx(addr);
        exp_rd = (m == 2'b10) ? ref2[i] : 32'd0;
        if (m != 2'b00) begin
            for (int k = 0; k < 2; k++) begin
                #1 chk("l2_stall_busy", {31'd0, b2.stall}, 32'd1);
                @(posedge clk); #1;
                chk_zero2("l2_bubble");
                @(negedge clk);
            end
        end
        #1 chk("l2_stall_done", {31'd0, b2.stall}, 32'd0);
        @(posedge clk); #1;
        chk("l2_wb",   {30'd0, b2.WB_out}, {30'd0, wb});
        chk("l2_rd",   b2.read_data_out, exp_rd);
        chk("l2_alu",  b2.ALUresult_out, addr);
        chk("l2_wreg", {27'd0, b2.write_register_out}, {27'd0, wr});
        if (m[0]) ref2[i] = data;
    endtask

    task automatic op2n(input logic [1:0] m, input logic [1:0] wb, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] wr);
        @(negedge clk);
        op2(m, wb, addr, data, wr);
    endtask

    task automatic op0n(input logic [1:0] m, input logic [1:0] wb, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] wr);
        logic [31:0] exp_rd;
        int i;
        @(negedge clk);
        b0.M_in = m; b0.WB_in = wb; b0.ALUresult_in = addr;
        b0.write_mem_data_in = data; b0.write_register_in = wr;
        i = widx(addr);
        exp_rd = (m == 2'b10) ? ref0[i] : 32'd0;
        #1 chk("l0_stall", {31'd0, b0.stall}, 32'd0);
        @(posedge clk); #1;
        chk("l0_wb",   {30'd0, b0.WB_out}, {30'd0, wb});
        chk("l0_rd",   b0.read_data_out, exp_rd);
        chk("l0_alu",  b0.ALUresult_out, addr);
        chk("l0_wreg", {27'd0, b0.write_register_out}, {27'd0, wr});
        if (m[0]) ref0[i] = data;
    endtask

    // Presents a store, lets one edge move into WAIT, then asserts reset mid-cycle.
    task automatic reset_mid_wait(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        b2.M_in = 2'b01; b2.WB_in = 2'b11; b2.ALUresult_in = addr;
        b2.write_mem_data_in = data; b2.write_register_in = 5'd9;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero2("rst_wait");
        chk("rst_wait_stall", {31'd0, b2.stall}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref2[i] = 32'd0;
            ref0[i] = 32'd0;
        end
        b2.M_in = 2'b00; b2.WB_in = 2'b00; b2.ALUresult_in = 32'd0;
        b2.write_mem_data_in = 32'd0; b2.write_register_in = 5'd0;
        b0.M_in = 2'b00; b0.WB_in = 2'b00; b0.ALUresult_in = 32'd0;
        b0.write_mem_data_in = 32'd0; b0.write_register_in = 5'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero2("reset");
        chk("reset_stall", {31'd0, b2.stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op2n(2'b00, 2'b10, 32'h0000_1234, 32'h0, 5'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_zero2("rst_async");
        @(negedge clk);
        rst_n = 1'b1;

        op2n(2'b01, 2'b01, 32'h0000_0010, 32'hDEAD_BEEF, 5'd3);
        op2n(2'b10, 2'b01, 32'h0000_0010, 32'h0, 5'd4);
        op2n(2'b01, 2'b00, 32'h0000_0404, 32'hA5A5_A5A5, 5'd0);
        op2n(2'b10, 2'b11, 32'h0000_0004, 32'h0, 5'd7);
        op2n(2'b10, 2'b11, 32'h0000_0403, 32'h0, 5'd8);
        op2n(2'b11, 2'b10, 32'h0000_0020, 32'd7, 5'd1);
        op2n(2'b10, 2'b10, 32'h0000_0020, 32'h0, 5'd2);

        reset_mid_wait(32'h0000_0040, 32'h1111_2222);
        rst_n = 1'b1;
        op2(2'b10, 2'b01, 32'h0000_0040, 32'h0, 5'd6);

        reset_mid_wait(32'h0000_0044, 32'h3333_4444);
        rst_n = 1'b1;
        op2(2'b01, 2'b11, 32'h0000_0044, 32'h3333_4444, 5'd9);
        op2n(2'b10, 2'b01, 32'h0000_0044, 32'h0, 5'd10);

        for (int n = 0; n < 40; n++) begin
            op2n(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2)
                     | 32'($urandom_range(0, 3)),
                 $urandom, 5'($urandom_range(0, 31)));
        end

        for (int n = 0; n < 10; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 1)) << 12);
            op0n(2'b01, 2'($urandom_range(0, 3)), a, $urandom, 5'($urandom_range(0, 31)));
            op0n(2'b10, 2'($urandom_range(0, 3)), a, 32'h0, 5'($urandom_range(0, 31)));
        end
        for (int n = 0; n < 20; n++) begin
            op0n(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 32'($urandom_range(0, 15)) << 2, $urandom, 5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
